// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and default latencies.
package md_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;
  localparam int unsigned CntW          = 16;

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at start, held in pending
// registers, and committed to HI/LO when the busy window expires.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start_In,
  input  logic [2:0]  Md_Op_In,
  input  logic [31:0] SrcA_In,
  input  logic [31:0] SrcB_In,
  output logic        Busy_Out,
  output logic [31:0] Hi_Out,
  output logic [31:0] Lo_Out
);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sa, sb_safe, quo_s, rem_s;
  logic [31:0]        ub_safe, quo_u, rem_u;
  logic               div_zero, div_ovf;

  assign prod_s = {{32{SrcA_In[31]}}, SrcA_In} * {{32{SrcB_In[31]}}, SrcB_In};
  assign prod_u = {32'd0, SrcA_In} * {32'd0, SrcB_In};

  // Divisor is forced to 1 when zero so the dividers never produce X; the result is dropped.
  assign div_zero = (SrcB_In == 32'd0);
  assign div_ovf  = (SrcA_In == 32'h8000_0000) && (SrcB_In == 32'hFFFF_FFFF);
  assign sa       = $signed(SrcA_In);
  assign sb_safe  = div_zero ? 32'sd1 : $signed(SrcB_In);
  assign ub_safe  = div_zero ? 32'd1 : SrcB_In;
  assign quo_s    = div_ovf ? 32'sh8000_0000 : sa / sb_safe;
  assign rem_s    = div_ovf ? 32'sd0 : sa % sb_safe;
  assign quo_u    = SrcA_In / ub_safe;
  assign rem_u    = SrcA_In % ub_safe;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    unique case (state_q)
      IDLE: begin
        if (Start_In) begin
          case (Md_Op_In)
            MD_MULT, MD_MULTU: begin
              pend_hi_d = (Md_Op_In == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
              pend_lo_d = (Md_Op_In == MD_MULT) ? prod_s[31:0] : prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CntW'(MULT_CYCLES);
              state_d   = MULT;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = (Md_Op_In == MD_DIV) ? rem_s : rem_u;
              pend_lo_d = (Md_Op_In == MD_DIV) ? quo_s : quo_u;
              pend_wr_d = !div_zero;
              cnt_d     = CntW'(DIV_CYCLES);
              state_d   = DIV;
            end
            MD_MTHI: hi_d = SrcA_In;
            MD_MTLO: lo_d = SrcA_In;
            default: ;
          endcase
        end
      end
      MULT, DIV: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign Busy_Out = (state_q != IDLE);
  assign Hi_Out   = hi_q;
  assign Lo_Out   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage, alongside the ALU.
- Fed by the forwarded E-stage operands (SrcA/WriteData paths); owns the HI/LO registers.
- Models multi-cycle latency with a busy window; the pause unit uses `Busy_Out|Start_In` to stall D-stage mult/div/mfhi/mflo/mthi/mtlo.
- HI/LO values feed the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- Clk  in  1  clock; the block's only clock
- Reset  in  1  synchronous, active-high reset
- Start_In  in  1  E-stage instr is an md_unit op, valid this cycle
- Md_Op_In  in  3  operation code (see package)
- SrcA_In  in  32  rs value (forwarded)
- SrcB_In  in  32  rt value (forwarded)
- Busy_Out  out  1  operation in progress
- Hi_Out  out  32  HI register
- Lo_Out  out  32  LO register

Behaviour:
- Reset state, sampled on Clk posedge when Reset=1:
  - Hi_Out=0, Lo_Out=0, Busy_Out=0, state=IDLE, counter=0.
  - Reset overrides everything, including an op in flight, which is discarded.
- States: IDLE, MULT, DIV.
- IDLE, Start_In=1, edge N:
  - MULT/MULTU: latch the 64-bit product into pending regs; counter=MULT_CYCLES; state→MULT.
  - DIV/DIVU: latch quotient/remainder into pending regs; counter=DIV_CYCLES; state→DIV.
  - MTHI: Hi←SrcA_In at edge N; Busy stays 0; state stays IDLE.
  - MTLO: Lo←SrcA_In at edge N; Busy stays 0; state stays IDLE.
  - Undefined Md_Op: no effect.
- MULT/DIV:
  - Busy_Out=1 from edge N for exactly the configured cycle count.
  - Counter decrements each edge.
  - On the edge where the counter goes 1→0: Hi/Lo←pending values, Busy_Out←0, state→IDLE.
  - New values are visible to mfhi in the same cycle Busy drops.
  - Until then, Hi_Out/Lo_Out hold their old values.
- Start_In while Busy_Out=1: ignored. The pause unit must prevent this; the bench asserts it never occurs in integrated runs.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32×32→64; same split.
  - div: signed; LO=quotient, truncated toward zero; HI=remainder, sign of dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divisor 0: full busy window still elapses; HI/LO unchanged at completion.
  - Signed overflow 0x80000000/−1: LO=0x80000000, HI=0.
- Operands are sampled only at Start; later changes on SrcA_In/SrcB_In have no effect.
- Interrupt/flush is not supported in P6. The instruction is committed once it enters E.

Decomposition:
- Package md_defs holds:
  - Md_Op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State encodings: IDLE/MULT/DIV.
  - Default cycle constants.
- Ctrl decodes op/funct to Md_Op and Start using the same package.
- No sub-module; arithmetic is behavioural `*`, `/`, `%` with $signed casts inside md_unit.

Test Plan:
- mult, SrcA=0xFFFFFFFF, SrcB=2 → Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu, same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles; HI/LO hold old values during busy.
- div, −7/2 (0xFFFFFFF9, 2) → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu, 7/2 → LO=3, HI=1.
- divu, 5/0 with HI=0x11, LO=0x22 → Busy 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi 0xDEADBEEF then mtlo 0x12345678 on consecutive cycles → each visible the next cycle; Busy stays 0 throughout.
- Reset asserted in cycle 3 of a mult → next cycle Busy=0, HI=LO=0; a new mult started afterwards completes normally in 5 cycles.
